// File: rtl/sync_fifo_gen.sv
// Single-clock parametrised FIFO with occupancy count, almost flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is one-cycle registered reads.
module sync_fifo_gen #(
    parameter int Width    = 4,
    parameter int Depth    = 16,
    parameter int AF_Level = Depth - 2,
    parameter int AE_Level = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [Width-1:0]           wdata,
    input  logic                       wen,
    input  logic                       ren,
    output logic [Width-1:0]           rdata,
    output logic                       rvalid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(Depth):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int IW = $clog2(Depth);
    localparam int AW = IW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW-1:0]    count_s;
    logic             full_s, empty_s;
    logic             wr_acc_s, rd_acc_s;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    // Status decode from pointer registers only; the wrap bit separates full from empty.
    always_comb begin
        count_s = wptr_q - rptr_q;
        empty_s = (wptr_q == rptr_q);
        full_s  = (wptr_q[IW-1:0] == rptr_q[IW-1:0]) && (wptr_q[AW-1] != rptr_q[AW-1]);
    end

    // Accept logic, pointer advance and sticky error next-state.
    always_comb begin
        wr_acc_s    = wen & ~full_s;
        rd_acc_s    = ren & ~empty_s;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q | (wen & full_s);
        underflow_d = underflow_q | (ren & empty_s);
        if (wr_acc_s) begin
            wptr_d = wptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wptr_d = wptr_q;
        end
        if (rd_acc_s) begin
            rptr_d = rptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Pointer and error flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q      <= {AW{1'b0}};
            rptr_q      <= {AW{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents survive reset and are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wptr_q[IW-1:0]] <= wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata  = mem_q[rptr_q[IW-1:0]];
    assign rvalid = ~empty_s;
`else
    logic [Width-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    // Registered read port: capture the head word on an accepted read, otherwise hold.
    always_comb begin
        rvalid_d = rd_acc_s;
        if (rd_acc_s) begin
            rdata_d = mem_q[rptr_q[IW-1:0]];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read data and valid registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q  <= {Width{1'b0}};
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
`endif

    assign count        = count_s;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_s >= AW'(AF_Level));
    assign almost_empty = (count_s <= AW'(AE_Level));
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
